// File: rtl/dmem_ctrl_pkg.sv
// Shared types and defaults for the data-side memory controller (dmem_ctrl).
package dmem_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] DEF_SEG_BASE  = 32'h0000_1000;
  localparam logic [ADDR_W-1:0] DEF_SEG_LIMIT = 32'h0000_FFFC;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_FILL,
    S_FILL_WAIT
  } dmem_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Misaligned or outside the legal data segment.
  function automatic logic seg_bad(input logic [ADDR_W-1:0] addr,
                                   input logic [ADDR_W-1:0] base,
                                   input logic [ADDR_W-1:0] limit);
    return (addr[1:0] != 2'b00) || (addr < base) || (addr > limit);
  endfunction

endpackage

// File: rtl/dmem_tag_array.sv
// Direct-mapped valid/tag/data store: combinational lookups, synchronous
// install (tag+data+valid) and data-only update ports, async valid clear.
module dmem_tag_array #(
  parameter int unsigned LINES  = 16,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned TAG_W  = 26,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              rd_hit_c,
  output logic [DATA_W-1:0] rd_data_c,
  input  logic [IDX_W-1:0]  chk_idx,
  input  logic [TAG_W-1:0]  chk_tag,
  output logic              chk_hit_c,
  input  logic              ins_en,
  input  logic [IDX_W-1:0]  ins_idx,
  input  logic [TAG_W-1:0]  ins_tag,
  input  logic [DATA_W-1:0] ins_data,
  input  logic              upd_en,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic [DATA_W-1:0] upd_data
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  assign rd_hit_c  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data_c = data_q[rd_idx];
  assign chk_hit_c = valid_q[chk_idx] && (tag_q[chk_idx] == chk_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (ins_en) begin
      valid_q[ins_idx] <= 1'b1;
    end
  end

  // Install is written last so it wins over an update to the same line.
  always_ff @(posedge clk) begin
    if (upd_en) begin
      data_q[upd_idx] <= upd_data;
    end
    if (ins_en) begin
      tag_q[ins_idx]  <= ins_tag;
      data_q[ins_idx] <= ins_data;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-side memory controller: write-through/no-write-allocate direct-mapped
// cache, single-entry write buffer, refill FSM. DMEM_STATS_EN adds hit/miss counters.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned       LINES     = 16,
  parameter logic [ADDR_W-1:0] SEG_BASE  = DEF_SEG_BASE,
  parameter logic [ADDR_W-1:0] SEG_LIMIT = DEF_SEG_LIMIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  input  logic              d_rd,
  input  logic              d_wr,
  output logic [DATA_W-1:0] d_rd_data,
  output logic              d_miss,
  output logic              d_segfault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
`ifdef DMEM_STATS_EN
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  dmem_state_e       state, state_nxt;
  wb_entry_t         wb;
  logic              wb_valid;
  logic              mem_req_nxt, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;

  logic              hit_c, wb_hit_c;
  logic [DATA_W-1:0] line_data_c;
  logic              seg_c, st_c, ld_c, ld_hit_c, st_acc_c, fill_start_c;
  logic              install_c, drain_c;
  logic              upd_en_c;
  logic [IDX_W-1:0]  upd_idx_c;
  logic [DATA_W-1:0] upd_data_c;

  // Request classification; a store shadows a simultaneous load.
  assign seg_c        = (d_rd || d_wr) && seg_bad(d_addr, SEG_BASE, SEG_LIMIT);
  assign st_c         = d_wr && !seg_c;
  assign ld_c         = d_rd && !d_wr && !seg_c;
  assign ld_hit_c     = ld_c && hit_c;
  assign st_acc_c     = st_c && !wb_valid;
  assign fill_start_c = ld_c && !hit_c && (state == S_IDLE) && !wb_valid;
  assign install_c    = (state == S_FILL_WAIT) && mem_rvalid;
  assign drain_c      = (state == S_WRITE) && mem_gnt;

  assign d_miss     = (ld_c && !hit_c) || (st_c && wb_valid);
  assign d_segfault = seg_c;

  dmem_tag_array #(
    .LINES  (LINES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_tags (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (d_addr[IDX_W+1:2]),
    .rd_tag    (d_addr[ADDR_W-1:IDX_W+2]),
    .rd_hit_c  (hit_c),
    .rd_data_c (line_data_c),
    .chk_idx   (wb.addr[IDX_W+1:2]),
    .chk_tag   (wb.addr[ADDR_W-1:IDX_W+2]),
    .chk_hit_c (wb_hit_c),
    .ins_en    (install_c),
    .ins_idx   (mem_addr[IDX_W+1:2]),
    .ins_tag   (mem_addr[ADDR_W-1:IDX_W+2]),
    .ins_data  (mem_rdata),
    .upd_en    (upd_en_c),
    .upd_idx   (upd_idx_c),
    .upd_data  (upd_data_c)
  );

  // Line data follows an accepted store hit, or the store as it drains if the
  // line was (re)installed while the store sat in the buffer.
  always_comb begin
    upd_en_c   = 1'b0;
    upd_idx_c  = d_addr[IDX_W+1:2];
    upd_data_c = d_wr_data;
    if (st_acc_c && hit_c) begin
      upd_en_c = 1'b1;
    end else if (drain_c && wb_hit_c) begin
      upd_en_c   = 1'b1;
      upd_idx_c  = wb.addr[IDX_W+1:2];
      upd_data_c = wb.data;
    end
  end

  // Next state and next memory-port values; buffered store always goes first.
  always_comb begin
    state_nxt     = state;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    case (state)
      S_IDLE: begin
        if (wb_valid) begin
          state_nxt     = S_WRITE;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b1;
          mem_addr_nxt  = wb.addr;
          mem_wdata_nxt = wb.data;
        end else if (fill_start_c) begin
          state_nxt    = S_FILL;
          mem_req_nxt  = 1'b1;
          mem_we_nxt   = 1'b0;
          mem_addr_nxt = d_addr;
        end
      end
      S_WRITE: begin
        if (mem_gnt) begin
          state_nxt   = S_IDLE;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
        end
      end
      S_FILL: begin
        if (mem_gnt) begin
          state_nxt   = S_FILL_WAIT;
          mem_req_nxt = 1'b0;
        end
      end
      S_FILL_WAIT: begin
        if (mem_rvalid) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wb_valid  <= 1'b0;
      wb        <= '0;
      d_rd_data <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if (drain_c) begin
        wb_valid <= 1'b0;
      end else if (st_acc_c) begin
        wb_valid <= 1'b1;
        wb       <= wb_entry_t'{addr: d_addr, data: d_wr_data};
      end
      if (ld_hit_c) begin
        d_rd_data <= line_data_c;
      end
    end
  end

`ifdef DMEM_STATS_EN
  // Replayed misses do not count; only misses that launch a fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (ld_hit_c)     hit_cnt  <= hit_cnt + 32'd1;
      if (fill_start_c) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: architectural memory model with a
// per-cycle compare process plus directed scenarios with literal expectations.
module tb_dmem_ctrl;

  logic        clk, rst_n;
  logic [31:0] d_addr, d_wr_data, d_rd_data;
  logic        d_rd, d_wr, d_miss, d_segfault;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int checks = 0;
  int failures = 0;

  dmem_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_addr     (d_addr),
    .d_wr_data  (d_wr_data),
    .d_rd       (d_rd),
    .d_wr       (d_wr),
    .d_rd_data  (d_rd_data),
    .d_miss     (d_miss),
    .d_segfault (d_segfault),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
`ifdef DMEM_STATS_EN
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
`endif
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory contents: backing store (updated on write grant) and architectural view
  // (updated when the core's store is accepted).
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] arch [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] rd_bmem(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return init_word(a);
  endfunction
  function automatic logic [31:0] rd_arch(input logic [31:0] a);
    if (arch.exists(a)) return arch[a];
    return init_word(a);
  endfunction
  function automatic logic exp_seg(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < 32'h0000_1000) || (a > 32'h0000_FFFC);
  endfunction

  // Backing memory: grant one cycle after request, read data rv_delay+1 cycles after grant.
  logic        gnt_hold = 1'b0;
  int          rv_delay = 1;
  int          wcnt, rd_dly;
  logic        rd_pend;
  logic [31:0] rd_addr, acc_addr, acc_wdata;
  logic        acc_we;

  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    wcnt = 0; rd_pend = 1'b0; rd_dly = 0;
    rd_addr = '0; acc_addr = '0; acc_wdata = '0; acc_we = 1'b0;
    forever begin
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      if (!rst_n) begin
        mem_gnt = 1'b0; wcnt = 0; rd_pend = 1'b0;
      end else begin
        if (mem_gnt) begin
          if (acc_we) bmem[acc_addr] = acc_wdata;
          else begin rd_pend = 1'b1; rd_dly = rv_delay; rd_addr = acc_addr; end
          mem_gnt = 1'b0; wcnt = 0;
        end else if (mem_req && !gnt_hold) begin
          wcnt++;
          if (wcnt >= 2) begin
            mem_gnt = 1'b1; acc_we = mem_we; acc_addr = mem_addr; acc_wdata = mem_wdata;
          end
        end
        if (rd_pend) begin
          if (rd_dly == 0) begin
            mem_rvalid = 1'b1; mem_rdata = rd_bmem(rd_addr); rd_pend = 1'b0;
          end else rd_dly--;
        end
      end
    end
  end

  // Per-cycle compare against the architectural model.
  logic [63:0] store_q [$];
  logic [32:0] txn_log [$];
  int          fill_cnt = 0;
  int          req_cycles = 0;
  logic        ld_pend = 1'b0;
  logic [31:0] ld_exp, last_miss = '0;
  logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;

  initial begin
    logic [63:0] s;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_d_rd_data", d_rd_data, 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        store_q.delete();
        ld_pend = 1'b0; prev_req = 1'b0; prev_gnt = 1'b0;
        continue;
      end
      if (ld_pend) begin
        check("load_data", d_rd_data, ld_exp);
        ld_pend = 1'b0;
      end
      if (prev_req && !prev_gnt) begin
        check("mem_hold_req", 32'(mem_req), 32'h1);
        check("mem_hold_we", 32'(mem_we), 32'(prev_we));
        check("mem_hold_addr", mem_addr, prev_addr);
        if (prev_we) check("mem_hold_wdata", mem_wdata, prev_wdata);
      end
      if (d_rd || d_wr) begin
        check("segfault", 32'(d_segfault), 32'(exp_seg(d_addr)));
        if (exp_seg(d_addr)) begin
          check("seg_no_miss", 32'(d_miss), 32'h0);
        end else if (d_wr) begin
          check("store_miss", 32'(d_miss), 32'(store_q.size() != 0));
          if (!d_miss) begin
            store_q.push_back({d_addr, d_wr_data});
            arch[d_addr] = d_wr_data;
          end
        end else if (!d_miss) begin
          ld_pend = 1'b1;
          ld_exp = rd_arch(d_addr);
        end else begin
          last_miss = d_addr;
        end
      end
      if (mem_req) req_cycles++;
      if (mem_req && mem_gnt) begin
        txn_log.push_back({mem_we, mem_addr});
        if (mem_we) begin
          check("wr_pending", 32'(store_q.size()), 32'h1);
          if (store_q.size() != 0) begin
            s = store_q.pop_front();
            check("wr_addr", mem_addr, s[63:32]);
            check("wr_data", mem_wdata, s[31:0]);
          end
        end else begin
          check("fill_after_drain", 32'(store_q.size()), 32'h0);
          check("fill_addr", mem_addr, last_miss);
          fill_cnt++;
        end
      end
      prev_req = mem_req; prev_gnt = mem_gnt; prev_we = mem_we;
      prev_addr = mem_addr; prev_wdata = mem_wdata;
    end
  end

  // Stimulus helpers: every call starts and ends 1 time unit after a rising edge.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output logic miss, output logic seg);
    d_rd = rd; d_wr = wr; d_addr = a; d_wr_data = wd;
    @(negedge clk);
    miss = d_miss; seg = d_segfault;
    @(posedge clk); #1;
    d_rd = 1'b0; d_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic retry(input logic wr, input logic [31:0] a, input logic [31:0] wd, output int tries);
    logic m, s;
    tries = 0; m = 1'b1;
    while (m && tries < 60) begin
      access(!wr, wr, a, wd, m, s);
      tries++;
    end
    check("retry_timeout", 32'(m), 32'h0);
  endtask

  task automatic wait_fill_grant(input int f0);
    int k;
    k = 0;
    while (fill_cnt == f0 && k < 40) begin idle(1); k++; end
    check("fill_grant_timeout", 32'(fill_cnt != f0), 32'h1);
  endtask

  logic [31:0] seg_addrs [3];
  logic [32:0] t;

  initial begin
    logic m, s;
    int   tries, f0, r0, n0;
    seg_addrs = '{32'h0000_0FFC, 32'h0001_0000, 32'h0000_1002};
    rst_n = 1'b0; d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wr_data = '0;
    bmem[32'h1000] = 32'hDEADBEEF;
    arch[32'h1000] = 32'hDEADBEEF;

    @(negedge clk);
    check("reset_d_rd_data", d_rd_data, 32'h0);
    check("reset_mem_req", 32'(mem_req), 32'h0);
    check("reset_mem_we", 32'(mem_we), 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    check("reset_d_miss", 32'(d_miss), 32'h0);
    check("reset_d_segfault", 32'(d_segfault), 32'h0);
    @(posedge clk); #3 rst_n = 1'b1;
    idle(1);

    // Cold load and replay.
    f0 = fill_cnt;
    access(1'b1, 1'b0, 32'h1000, '0, m, s);
    check("t1_cold_miss", 32'(m), 32'h1);
    check("t1_cold_seg", 32'(s), 32'h0);
    retry(1'b0, 32'h1000, '0, tries);
    check("t1_data", d_rd_data, 32'hDEADBEEF);
    check("t1_fill_count", 32'(fill_cnt - f0), 32'h1);
    t = txn_log[txn_log.size()-1];
    check("t1_fill_txn", t[31:0], 32'h1000);

    // Segfaults never reach memory; top of segment is legal.
    idle(2);
    r0 = req_cycles;
    for (int i = 0; i < 3; i++) begin
      access(1'b1, 1'b0, seg_addrs[i], '0, m, s);
      check("t2_seg", 32'(s), 32'h1);
      check("t2_seg_miss", 32'(m), 32'h0);
    end
    idle(2);
    check("t2_no_mem_req", 32'(req_cycles - r0), 32'h0);
    check("t2_rd_data_held", d_rd_data, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h0000_FFFC, '0, m, s);
    check("t2_limit_legal", 32'(s), 32'h0);
    idle(10);

    // Store then load of the same address: write drains before the fill.
    n0 = txn_log.size();
    access(1'b0, 1'b1, 32'h2000, 32'h12345678, m, s);
    check("t3_store_accept", 32'(m), 32'h0);
    retry(1'b0, 32'h2000, '0, tries);
    check("t3_data", d_rd_data, 32'h12345678);
    check("t3_txn_count", 32'(txn_log.size() - n0), 32'h2);
    if (txn_log.size() >= n0 + 2) begin
      t = txn_log[n0];
      check("t3_first_is_write", {31'h0, t[32]}, 32'h1);
      check("t3_first_addr", t[31:0], 32'h2000);
      t = txn_log[n0+1];
      check("t3_second_is_read", {31'h0, t[32]}, 32'h0);
    end

    // Full write buffer back-pressures a second store.
    idle(2);
    gnt_hold = 1'b1;
    access(1'b0, 1'b1, 32'h3000, 32'h0000_00A1, m, s);
    check("t4_first_store", 32'(m), 32'h0);
    access(1'b0, 1'b1, 32'h3004, 32'h0000_00B2, m, s);
    check("t4_second_store_miss", 32'(m), 32'h1);
    idle(3);
    check("t4_req_held", 32'(mem_req), 32'h1);
    check("t4_req_addr", mem_addr, 32'h3000);
    gnt_hold = 1'b0;
    retry(1'b1, 32'h3004, 32'h0000_00B2, tries);
    check("t4_retry_needed", 32'(tries > 1), 32'h1);
    idle(10);
    check("t4_mem_3000", rd_bmem(32'h3000), 32'h0000_00A1);
    check("t4_mem_3004", rd_bmem(32'h3004), 32'h0000_00B2);

    // Hit served while a fill waits for read data.
    retry(1'b0, 32'h1000, '0, tries);
    rv_delay = 6;
    f0 = fill_cnt;
    access(1'b1, 1'b0, 32'h1040, '0, m, s);
    check("t5_fill_miss", 32'(m), 32'h1);
    wait_fill_grant(f0);
    access(1'b1, 1'b0, 32'h1000, '0, m, s);
    check("t5_hit_no_miss", 32'(m), 32'h0);
    check("t5_hit_data", d_rd_data, 32'hDEADBEEF);
    check("t5_fill_outstanding", 32'(rd_pend), 32'h1);
    retry(1'b0, 32'h1040, '0, tries);
    check("t5_fill_data", d_rd_data, 32'h5A5A_1040);
    rv_delay = 1;

    // Reset in the middle of a fill abandons it.
    idle(2);
    rv_delay = 8;
    f0 = fill_cnt;
    access(1'b1, 1'b0, 32'h1000, '0, m, s);
    check("t6_pre_miss", 32'(m), 32'h1);
    wait_fill_grant(f0);
    idle(1);
    #2 rst_n = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    idle(1);
    rv_delay = 1;
    f0 = fill_cnt;
    access(1'b1, 1'b0, 32'h1000, '0, m, s);
    check("t6_post_reset_miss", 32'(m), 32'h1);
`ifdef DMEM_STATS_EN
    check("t6_hit_cnt", hit_cnt, 32'd0);
    check("t6_miss_cnt", miss_cnt, 32'd1);
`endif
    retry(1'b0, 32'h1000, '0, tries);
    check("t6_data", d_rd_data, 32'hDEADBEEF);
    check("t6_new_fill", 32'(fill_cnt - f0), 32'h1);

    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
